gpio_bank: RTL



---
 rtl/gpio_bank.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: N-pin GPIO bank built from io pad cells, with register access, input sync and edge IRQ.
// Define GPIO_DEBOUNCE_EN to add per-pin debounce counters (threshold in DB_LIM).

module io (
  input  logic di,
  input  logic oe,
  input  logic ie,
  input  logic pu,
  input  logic pd,
  output logic dc,
  inout  wire  pad
);
  // Pull is driven only while the output driver is off; pull-up wins if both are set.
  assign pad = oe ? di : ((pu | pd) ? pu : 1'bz);
  assign dc  = ie ? pad : pu;
endmodule

module gpio_bank #(
  parameter int unsigned N      = 8,
  parameter int unsigned DBW    = 8,
  parameter int unsigned DB_RST = 4
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [N-1:0] pad,
  input  logic         sel,
  input  logic         we,
  input  logic [3:0]   addr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         rvalid,
  output logic         irq
);
  typedef enum logic [3:0] {
    A_OUT      = 4'd0,
    A_OE       = 4'd1,
    A_IE       = 4'd2,
    A_PU       = 4'd3,
    A_PD       = 4'd4,
    A_IN       = 4'd5,
    A_IRQ_EN   = 4'd6,
    A_IRQ_STAT = 4'd7,
    A_EDGE     = 4'd8,
    A_DB_LIM   = 4'd9
  } reg_addr_e;

  logic [N-1:0] out_r, oe_r, ie_r, pu_r, pd_r, irq_en, edge_sel, stat;
  logic [N-1:0] dc, sync_meta, sync, stab, prev;
  logic [N-1:0] hit, clr, stat_next, rd_mux, db_rd;
  logic         wr, rd;

  assign wr = sel & we;
  assign rd = sel & ~we;

  for (genvar i = 0; i < N; i++) begin : g_pin
    io u_io (
      .di  (out_r[i]),
      .oe  (oe_r[i]),
      .ie  (ie_r[i]),
      .pu  (pu_r[i]),
      .pd  (pd_r[i]),
      .dc  (dc[i]),
      .pad (pad[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_r    <= '0;
      oe_r     <= '0;
      ie_r     <= '0;
      pu_r     <= '0;
      pd_r     <= '0;
      irq_en   <= '0;
      edge_sel <= '0;
    end else if (wr) begin
      case (addr)
        A_OUT:    out_r    <= wdata;
        A_OE:     oe_r     <= wdata;
        A_IE:     ie_r     <= wdata;
        A_PU:     pu_r     <= wdata;
        A_PD:     pd_r     <= wdata;
        A_IRQ_EN: irq_en   <= wdata;
        A_EDGE:   edge_sel <= wdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
      prev      <= '0;
    end else begin
      sync_meta <= dc;
      sync      <= sync_meta;
      prev      <= stab;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned W = (N > DBW) ? N : DBW;

  logic [DBW-1:0] db_lim, lim_eff;
  logic [DBW-1:0] cnt [N];
  logic [W-1:0]   wdata_ext, lim_ext;

  assign wdata_ext = W'(wdata);
  assign lim_ext   = W'(db_lim);
  assign db_rd     = lim_ext[N-1:0];
  assign lim_eff   = (db_lim == '0) ? DBW'(1) : db_lim;

  always_ff @(posedge clk) begin
    if (rst)
      db_lim <= DBW'(DB_RST);
    else if (wr && addr == A_DB_LIM)
      db_lim <= wdata_ext[DBW-1:0];
  end

  // >= rather than == so a threshold lowered mid-count still releases the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab <= '0;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sync[i] == stab[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= lim_eff) begin
          stab[i] <= sync[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign db_rd = '0;

  always_ff @(posedge clk) begin
    if (rst) stab <= '0;
    else     stab <= sync;
  end
`endif

  always_comb begin
    clr       = (wr && addr == A_IRQ_STAT) ? wdata : '0;
    hit       = irq_en & ((edge_sel & stab & ~prev) | (~edge_sel & ~stab & prev));
    stat_next = (stat & ~clr) | hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat <= '0;
      irq  <= 1'b0;
    end else begin
      stat <= stat_next;
      irq  <= |stat_next;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:      rd_mux = out_r;
      A_OE:       rd_mux = oe_r;
      A_IE:       rd_mux = ie_r;
      A_PU:       rd_mux = pu_r;
      A_PD:       rd_mux = pd_r;
      A_IN:       rd_mux = stab;
      A_IRQ_EN:   rd_mux = irq_en;
      A_IRQ_STAT: rd_mux = stat;
      A_EDGE:     rd_mux = edge_sel;
      A_DB_LIM:   rd_mux = db_rd;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= rd_mux;
    end
  end
endmodule
